// File: rtl/uart_tx_arb_if.sv
// Byte-stream bundle between two framed sources, the arbiter and the UART
// transmitter. The arbiter uses the slave view. The environment that drives
// the sources and the transmitter-side ready uses the master view.
interface uart_tx_arb_if;
    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_last;
    logic       s0_ready;

    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_last;
    logic       s1_ready;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    logic [1:0] grant;
    logic       abort;

    modport slave (
        input  s0_valid, s0_data, s0_last,
        output s0_ready,
        input  s1_valid, s1_data, s1_last,
        output s1_ready,
        output tx_valid, tx_data,
        input  tx_ready,
        output grant, abort
    );

    modport master (
        output s0_valid, s0_data, s0_last,
        input  s0_ready,
        output s1_valid, s1_data, s1_last,
        input  s1_ready,
        input  tx_valid, tx_data,
        output tx_ready,
        input  grant, abort
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Two-source, frame-atomic, round-robin arbiter in front of a UART transmitter.
// Source 0 carries command responses and source 1 carries async notifications.
// Once a source wins, its whole frame passes straight through to the transmitter.
// Another grant follows only after a one-cycle IDLE bubble.
// A granted source that goes silent mid-frame for TIMEOUT_CYC cycles loses its
// grant, and abort pulses for one cycle.
module uart_tx_arb #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic        ptr;
    logic [15:0] stall_cnt;
    logic        abort_q;
    logic [1:0]  grant_q;

    logic        cur_valid;
    logic        cur_last;
    logic        pick_s1;
    logic        own0;
    logic        own1;
    logic        pass_valid;

    // The owner's handshake inputs are selected here for the sequencing logic.
    // The IDLE-cycle winner is also chosen here. The pointer breaks ties only
    // when both sources request.
    always_comb begin
        cur_valid = (state == OWN1) ? bus.s1_valid : bus.s0_valid;
        cur_last  = (state == OWN1) ? bus.s1_last  : bus.s0_last;
        pick_s1   = bus.s1_valid && (!bus.s0_valid || ptr);
    end

    // The pass-through path carries bytes with zero latency from the owner to
    // the transmitter. It is gated off while reset is asserted, so a frame cut
    // by reset cannot leak one more beat on the reset edge. tx_data is forced
    // to zero whenever nothing valid is offered.
    always_comb begin
        own0         = rst && (state == OWN0);
        own1         = rst && (state == OWN1);
        pass_valid   = (own0 && bus.s0_valid) || (own1 && bus.s1_valid);
        bus.tx_valid = pass_valid;
        bus.tx_data  = 8'h00;
        if (own0 && bus.s0_valid) begin
            bus.tx_data = bus.s0_data;
        end else if (own1 && bus.s1_valid) begin
            bus.tx_data = bus.s1_data;
        end
        bus.s0_ready = own0 && bus.tx_ready;
        bus.s1_ready = own1 && bus.tx_ready;
    end

    // The ownership FSM, round-robin pointer, stall counter and registered
    // grant/abort outputs are all updated here. Each grant ends on the owner's
    // last beat or on a stall timeout. The pointer is then pointed at the
    // source that did not just own the link.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            stall_cnt <= 16'd0;
            abort_q   <= 1'b0;
            grant_q   <= 2'b00;
        end else begin
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    stall_cnt <= 16'd0;
                    if (bus.s0_valid || bus.s1_valid) begin
                        if (pick_s1) begin
                            state   <= OWN1;
                            grant_q <= 2'b10;
                        end else begin
                            state   <= OWN0;
                            grant_q <= 2'b01;
                        end
                    end
                end

                OWN0, OWN1: begin
                    if (cur_valid && bus.tx_ready && cur_last) begin
                        state     <= IDLE;
                        grant_q   <= 2'b00;
                        ptr       <= (state == OWN0);
                        stall_cnt <= 16'd0;
                    end else if (!cur_valid && (stall_cnt == STALL_LIMIT)) begin
                        state     <= IDLE;
                        grant_q   <= 2'b00;
                        abort_q   <= 1'b1;
                        ptr       <= (state == OWN0);
                        stall_cnt <= 16'd0;
                    end else if (!cur_valid) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end else begin
                        stall_cnt <= 16'd0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    grant_q   <= 2'b00;
                    stall_cnt <= 16'd0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb. A behavioural ownership model predicts every output on
// every cycle. Directed frame scenarios use hand-computed grant/byte/abort
// expectations. A randomized phase varies source activity, sink readiness and
// occasional reset.
module tb_uart_tx_arb;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arb_if bus ();

    uart_tx_arb #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit model_en = 1'b0;

    logic [8:0] srcq0[$];
    logic [8:0] srcq1[$];
    logic [7:0] tx_log[$];
    logic [1:0] g_log[$];
    logic       a_log[$];

    int  v_pct0   = 100;
    int  v_pct1   = 100;
    int  rdy_pct  = 100;
    int  fill_pct = 0;
    bit  rand_rst = 1'b0;
    bit  rst_hold = 1'b1;

    logic [7:0] f35 [6] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'hA6};

    // Reference model: who owns the link, whose turn it is, and how long the
    // owner has been silent.
    int   m_owner = -1;
    int   m_prio  = 0;
    int   m_quiet = 0;
    logic m_abort = 1'b0;
    logic m_v;
    logic m_l;

    assign m_v = (m_owner == 1) ? bus.s1_valid : bus.s0_valid;
    assign m_l = (m_owner == 1) ? bus.s1_last  : bus.s0_last;

    // Advance the model: pick a winner when nobody owns the link. A grant ends
    // on the owner's last accepted byte or after TO silent cycles.
    always @(posedge clk) begin
        m_abort <= 1'b0;
        if (rst !== 1'b1) begin
            m_owner <= -1;
            m_prio  <= 0;
            m_quiet <= 0;
        end else if (m_owner < 0) begin
            m_quiet <= 0;
            if (bus.s0_valid && bus.s1_valid) m_owner <= m_prio;
            else if (bus.s0_valid)            m_owner <= 0;
            else if (bus.s1_valid)            m_owner <= 1;
        end else if (m_v && bus.tx_ready && m_l) begin
            m_owner <= -1;
            m_prio  <= 1 - m_owner;
        end else if (!m_v) begin
            if (m_quiet == TO - 1) begin
                m_owner <= -1;
                m_prio  <= 1 - m_owner;
                m_abort <= 1'b1;
                m_quiet <= 0;
            end else begin
                m_quiet <= m_quiet + 1;
            end
        end else begin
            m_quiet <= 0;
        end
    end

    task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", nm, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic checkOutput();
        logic [1:0] eg;
        logic       ev;
        logic [7:0] ed;
        logic       er0;
        logic       er1;
        bit         live;
        live = (m_owner >= 0) && (rst === 1'b1);
        eg   = (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00);
        ev   = live && ((m_owner == 0) ? bus.s0_valid : bus.s1_valid);
        ed   = ev ? ((m_owner == 0) ? bus.s0_data : bus.s1_data) : 8'h00;
        er0  = live && (m_owner == 0) && bus.tx_ready;
        er1  = live && (m_owner == 1) && bus.tx_ready;
        cmp("grant",    16'(bus.grant),    16'(eg));
        cmp("abort",    16'(bus.abort),    16'(m_abort));
        cmp("tx_valid", 16'(bus.tx_valid), 16'(ev));
        cmp("tx_data",  16'(bus.tx_data),  16'(ed));
        cmp("s0_ready", 16'(bus.s0_ready), 16'(er0));
        cmp("s1_ready", 16'(bus.s1_ready), 16'(er1));
    endtask

    // Compare the DUT against the model mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (model_en) checkOutput();
    end

    task automatic pushByte(input int src, input logic [7:0] d, input logic l);
        if (src == 0) srcq0.push_back({l, d});
        else          srcq1.push_back({l, d});
    endtask

    task automatic pushRandFrame(input int src);
        int len;
        len = $urandom_range(6, 1);
        for (int k = 0; k < len; k++) pushByte(src, 8'($urandom), (k == len - 1));
    endtask

    task automatic clearLogs();
        tx_log.delete();
        g_log.delete();
        a_log.delete();
    endtask

    // Drive ncyc cycles of source/sink activity. This starts just after a
    // rising edge. Bytes leave a source's queue only when they are accepted.
    task automatic applyStimulus(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            bus.tx_ready = ($urandom_range(99) < rdy_pct);
            if (srcq0.size() > 0 && $urandom_range(99) < v_pct0) begin
                bus.s0_valid = 1'b1;
                {bus.s0_last, bus.s0_data} = srcq0[0];
            end else begin
                bus.s0_valid = 1'b0;
                bus.s0_data  = 8'($urandom);
                bus.s0_last  = 1'($urandom);
            end
            if (srcq1.size() > 0 && $urandom_range(99) < v_pct1) begin
                bus.s1_valid = 1'b1;
                {bus.s1_last, bus.s1_data} = srcq1[0];
            end else begin
                bus.s1_valid = 1'b0;
                bus.s1_data  = 8'($urandom);
                bus.s1_last  = 1'($urandom);
            end
            rst = rand_rst ? ($urandom_range(299) != 0) : rst_hold;
            @(negedge clk);
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) tx_log.push_back(bus.tx_data);
            g_log.push_back(bus.grant);
            a_log.push_back(bus.abort);
            if (bus.s0_valid && bus.s0_ready === 1'b1) void'(srcq0.pop_front());
            if (bus.s1_valid && bus.s1_ready === 1'b1) void'(srcq1.pop_front());
            if (srcq0.size() == 0 && $urandom_range(99) < fill_pct) pushRandFrame(0);
            if (srcq1.size() == 0 && $urandom_range(99) < fill_pct) pushRandFrame(1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        srcq0.delete();
        srcq1.delete();
        rand_rst = 1'b0;
        fill_pct = 0;
        rst_hold = 1'b0;
        applyStimulus(1);
        rst_hold = 1'b1;
        clearLogs();
    endtask

    function automatic int countAborts();
        int c;
        c = 0;
        foreach (a_log[k]) if (a_log[k] === 1'b1) c++;
        return c;
    endfunction

    int         ph_v0 [4] = '{90, 30, 6, 95};
    int         ph_v1 [4] = '{90, 70, 6, 95};
    int         ph_r  [4] = '{80, 50, 90, 15};
    logic [1:0] runs[$];
    logic [1:0] prev;

    initial begin
        bus.s0_valid = 1'b0; bus.s0_data = 8'h00; bus.s0_last = 1'b0;
        bus.s1_valid = 1'b0; bus.s1_data = 8'h00; bus.s1_last = 1'b0;
        bus.tx_ready = 1'b0;
        doReset();
        model_en = 1'b1;

        // Reset state and a single-source six-byte frame.
        v_pct0 = 100; v_pct1 = 100; rdy_pct = 100;
        for (int k = 0; k < 6; k++) pushByte(0, f35[k], (k == 5));
        applyStimulus(10);
        cmp("rst_grant", 16'(g_log[0]), 16'd0);
        cmp("f35_count", 16'(tx_log.size()), 16'd6);
        for (int k = 0; k < 6; k++) cmp("f35_byte", 16'(tx_log[k]), 16'(f35[k]));
        for (int k = 1; k <= 6; k++) cmp("f35_grant", 16'(g_log[k]), 16'd1);
        cmp("f35_end", 16'(g_log[7]), 16'd0);

        // Both sources request together: s0 goes first, one bubble, then s1.
        doReset();
        for (int k = 0; k < 6; k++) pushByte(0, 8'(8'h10 + k), (k == 5));
        for (int k = 0; k < 6; k++) pushByte(1, 8'(8'h20 + k), (k == 5));
        applyStimulus(18);
        cmp("cont_g6",  16'(g_log[6]),  16'd1);
        cmp("cont_g7",  16'(g_log[7]),  16'd0);
        cmp("cont_g8",  16'(g_log[8]),  16'd2);
        cmp("cont_g13", 16'(g_log[13]), 16'd2);
        cmp("cont_g14", 16'(g_log[14]), 16'd0);
        cmp("cont_cnt", 16'(tx_log.size()), 16'd12);
        cmp("cont_b5",  16'(tx_log[5]), 16'h15);
        cmp("cont_b6",  16'(tx_log[6]), 16'h20);

        // Round-robin across three frames per source.
        doReset();
        for (int f = 0; f < 3; f++) begin
            pushByte(0, 8'h30, 1'b0); pushByte(0, 8'h31, 1'b1);
            pushByte(1, 8'h40, 1'b0); pushByte(1, 8'h41, 1'b1);
        end
        applyStimulus(25);
        runs.delete();
        prev = 2'b00;
        foreach (g_log[k]) begin
            if (g_log[k] != 2'b00 && g_log[k] != prev) runs.push_back(g_log[k]);
            prev = g_log[k];
        end
        cmp("rr_runs", 16'(runs.size()), 16'd6);
        for (int k = 0; k < 6 && k < runs.size(); k++)
            cmp("rr_order", 16'(runs[k]), (k % 2 == 0) ? 16'd1 : 16'd2);

        // Sink backpressure far longer than the timeout never aborts.
        doReset();
        for (int k = 0; k < 6; k++) pushByte(0, f35[k], (k == 5));
        applyStimulus(3);
        rdy_pct = 0;
        applyStimulus(3000);
        rdy_pct = 100;
        applyStimulus(10);
        cmp("bp_abort", 16'(countAborts()), 16'd0);
        cmp("bp_grant", 16'(g_log[1500]), 16'd1);
        cmp("bp_count", 16'(tx_log.size()), 16'd6);
        cmp("bp_last",  16'(tx_log[5]), 16'hA6);

        // s1 stalls after two bytes: timeout, abort, then pending s0 is granted.
        doReset();
        pushByte(1, 8'h51, 1'b0); pushByte(1, 8'h52, 1'b0);
        applyStimulus(1);
        pushByte(0, 8'h61, 1'b0); pushByte(0, 8'h62, 1'b0); pushByte(0, 8'h63, 1'b1);
        applyStimulus(30);
        cmp("to_g18",   16'(g_log[18]), 16'd2);
        cmp("to_a18",   16'(a_log[18]), 16'd0);
        cmp("to_a19",   16'(a_log[19]), 16'd1);
        cmp("to_g19",   16'(g_log[19]), 16'd0);
        cmp("to_g20",   16'(g_log[20]), 16'd1);
        cmp("to_nabrt", 16'(countAborts()), 16'd1);
        cmp("to_count", 16'(tx_log.size()), 16'd5);

        // Reset mid-frame drops the frame silently; the retry starts from SOF.
        doReset();
        for (int k = 0; k < 6; k++) pushByte(0, 8'(8'hA5 + k), (k == 5));
        applyStimulus(4);
        rst_hold = 1'b0;
        applyStimulus(1);
        rst_hold = 1'b1;
        srcq0.delete();
        for (int k = 0; k < 6; k++) pushByte(0, 8'(8'hA5 + k), (k == 5));
        applyStimulus(10);
        cmp("mr_g5",    16'(g_log[5]), 16'd0);
        cmp("mr_g6",    16'(g_log[6]), 16'd1);
        cmp("mr_abort", 16'(countAborts()), 16'd0);
        cmp("mr_count", 16'(tx_log.size()), 16'd9);
        cmp("mr_sof",   16'(tx_log[3]), 16'hA5);

        // Randomized traffic against the model.
        doReset();
        for (int p = 0; p < 4; p++) begin
            v_pct0 = ph_v0[p]; v_pct1 = ph_v1[p]; rdy_pct = ph_r[p];
            fill_pct = 40; rand_rst = 1'b1;
            applyStimulus(600);
        end
        rand_rst = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
